// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package fetch_stage_pkg;

  // Instruction word width, shared with decode_stage.
  localparam int INSTR_W = 32;

  // Canonical NOP (addi x0,x0,0) and the default boot address.
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0]        RESET_PC_DEF  = 32'h0000_0000;

  // Fetch controller states.
  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  // A fetch target is usable only when it is word-aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// Output register plus one-entry skid so a decode stall never drops a word
// that memory has already returned.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic               i_in_valid,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic [31:0]        i_in_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [31:0]        r_out_pc;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [31:0]        r_skid_pc;
  logic               w_slot_free;

  // The output slot can accept a new word when empty or being consumed now.
  assign w_slot_free = !r_out_valid || !i_stall;

  // Move words input -> skid -> output, oldest first; flush empties both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= 32'h0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= 32'h0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_skid_valid <= 1'b0;
    end else if (w_slot_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_pc     <= r_skid_pc;
        r_skid_valid <= i_in_valid;
        if (i_in_valid) begin
          r_skid_instr <= i_in_instr;
          r_skid_pc    <= i_in_pc;
        end
      end else if (i_in_valid) begin
        r_out_valid <= 1'b1;
        r_out_instr <= i_in_instr;
        r_out_pc    <= i_in_pc;
      end else begin
        r_out_valid <= 1'b0;
        r_out_instr <= NOP_INSTR;
      end
    end else if (i_in_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= i_in_instr;
      r_skid_pc    <= i_in_pc;
    end
  end

  assign o_valid = r_out_valid;
  assign o_instr = r_out_instr;
  assign o_pc    = r_out_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches and handles
// branch/jump redirects, including draining a fetch that cannot be cancelled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [31:0]        if_pc,
  output logic               fetch_fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_drain_addr;
  logic         r_fault;
  logic         w_capture;
  logic         w_out_valid;
  logic         w_bad_target;

  assign w_bad_target = redirect_valid && is_misaligned(redirect_pc);

  // A returned word is kept only on a normal fetch with no redirect this edge.
  assign w_capture = (r_state == S_FETCH) && imem_ready && !redirect_valid;

  // PC, controller state, drain address and sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_fault      <= 1'b0;
    end else begin
      if (w_bad_target && r_state != S_FAULT) begin
        r_fault <= 1'b1;
      end
      case (r_state)
        S_BOOT: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          r_state <= w_bad_target ? S_FAULT : S_FETCH;
        end
        S_FETCH: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (imem_ready) begin
              r_state <= w_bad_target ? S_FAULT : S_FETCH;
            end else begin
              // Memory still owes us the old word; hold its address until it lands.
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ready) begin
            r_pc    <= r_pc + 32'd4;
            // Output held by a stall means this word went to the skid slot.
            r_state <= (w_out_valid && stall) ? S_STALL : S_FETCH;
          end
        end
        S_STALL: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= w_bad_target ? S_FAULT : S_FETCH;
          end else if (!stall) begin
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          if (imem_ready) begin
            r_state <= (r_fault || w_bad_target) ? S_FAULT : S_FETCH;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign fetch_fault = r_fault;

  fetch_skid_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk        (clk),
    .rst        (reset),
    .i_flush    (redirect_valid),
    .i_stall    (stall),
    .i_in_valid (w_capture),
    .i_in_instr (imem_rdata),
    .i_in_pc    (r_pc),
    .o_valid    (w_out_valid),
    .o_instr    (if_instruction),
    .o_pc       (if_pc)
  );

  assign if_valid = w_out_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, slow memory,
// redirect with drain, redirect with same-cycle ready, misaligned fault.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: answers after ready_delay wait cycles with addr ^ A5A5_0000.
  logic [3:0] ready_delay = 4'd0;
  logic [3:0] mem_wait    = 4'd0;

  assign imem_ready = imem_req && (mem_wait >= ready_delay);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (!imem_req || imem_ready) mem_wait <= 4'd0;
    else                         mem_wait <= mem_wait + 4'd1;
  end

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_req",   {31'h0, imem_req},    32'h0);
    check_val("rst_addr",  imem_addr,            32'h0);
    check_val("rst_valid", {31'h0, if_valid},    32'h0);
    check_val("rst_instr", if_instruction,       32'h0000_0013);
    check_val("rst_pc",    if_pc,                32'h0);
    check_val("rst_fault", {31'h0, fetch_fault}, 32'h0);
    reset = 1'b0;

    // 1: streaming at one word per cycle
    @(negedge clk);
    check_val("t1_req",    {31'h0, imem_req}, 32'h1);
    check_val("t1_addr0",  imem_addr,         32'h0);
    check_val("t1_valid0", {31'h0, if_valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("t1_addr",  imem_addr,         32'(4 * k + 4));
      check_val("t1_valid", {31'h0, if_valid}, 32'h1);
      check_val("t1_pc",    if_pc,             32'(4 * k));
      check_val("t1_instr", if_instruction,    32'(4 * k) ^ 32'hA5A5_0000);
    end

    // 2: three stall cycles; word 0x0C goes to skid, then appears in order
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("t2_req",   {31'h0, imem_req}, 32'h0);
      check_val("t2_pc",    if_pc,             32'h8);
      check_val("t2_instr", if_instruction,    32'hA5A5_0008);
    end
    stall = 1'b0;
    @(negedge clk);
    check_val("t2_pc_c",   if_pc,             32'hC);
    check_val("t2_ins_c",  if_instruction,    32'hA5A5_000C);
    check_val("t2_addr10", imem_addr,         32'h10);
    check_val("t2_reqon",  {31'h0, imem_req}, 32'h1);
    @(negedge clk);
    check_val("t2_pc_10",  if_pc,             32'h10);
    check_val("t2_addr14", imem_addr,         32'h14);

    // 3: memory answers after three wait cycles
    ready_delay = 4'd3;
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge clk);
        check_val("t3_hold_addr", imem_addr,         32'(32'h14 + 4 * r));
        check_val("t3_wait_vld",  {31'h0, if_valid}, 32'h0);
      end
      @(negedge clk);
      check_val("t3_vld",   {31'h0, if_valid}, 32'h1);
      check_val("t3_pc",    if_pc,             32'(32'h14 + 4 * r));
      check_val("t3_instr", if_instruction,    32'(32'h14 + 4 * r) ^ 32'hA5A5_0000);
      check_val("t3_next",  imem_addr,         32'(32'h18 + 4 * r));
    end

    // 4: redirect to 0x100 while the 0x1C fetch is still pending
    check_val("t4_pend", {31'h0, imem_ready}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("t4_flush", {31'h0, if_valid}, 32'h0);
    check_val("t4_req",   {31'h0, imem_req}, 32'h1);
    check_val("t4_drain", imem_addr,         32'h1C);
    @(negedge clk);
    check_val("t4_drain", imem_addr,         32'h1C);
    @(negedge clk);
    check_val("t4_drain", imem_addr,         32'h1C);
    @(negedge clk);
    check_val("t4_new",     imem_addr,         32'h100);
    check_val("t4_discard", {31'h0, if_valid}, 32'h0);
    ready_delay = 4'd0;
    @(negedge clk);
    check_val("t4_vld",   {31'h0, if_valid}, 32'h1);
    check_val("t4_pc",    if_pc,             32'h100);
    check_val("t4_instr", if_instruction,    32'hA5A5_0100);

    // 5: redirect coinciding with ready=1 while decode is stalled
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("t5_vld",   {31'h0, if_valid}, 32'h0);
    check_val("t5_nop",   if_instruction,    32'h0000_0013);
    check_val("t5_addr",  imem_addr,         32'h200);
    @(negedge clk);
    check_val("t5_pc",    if_pc,             32'h200);
    check_val("t5_vld2",  {31'h0, if_valid}, 32'h1);
    @(negedge clk);
    check_val("t5_stl",   {31'h0, imem_req}, 32'h0);
    check_val("t5_hold",  if_pc,             32'h200);
    stall = 1'b0;
    @(negedge clk);
    check_val("t5_skid",  if_pc,             32'h204);

    // 6: misaligned redirect -> sticky fault, no further fetches
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      check_val("t6_fault", {31'h0, fetch_fault}, 32'h1);
      check_val("t6_req",   {31'h0, imem_req},    32'h0);
      check_val("t6_vld",   {31'h0, if_valid},    32'h0);
    end
    reset = 1'b1;
    #1;
    check_val("t6_rst_fault", {31'h0, fetch_fault}, 32'h0);
    check_val("t6_rst_addr",  imem_addr,            32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("t6_restart_req",  {31'h0, imem_req}, 32'h1);
    check_val("t6_restart_addr", imem_addr,         32'h0);
    @(negedge clk);
    check_val("t6_restart_pc",   if_pc,             32'h0);
    check_val("t6_restart_vld",  {31'h0, if_valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
